// File: rtl/adc_spi_ctrl.sv
// adc_spi_ctrl: periodic 16-bit SPI frame sequencer for a serial ADC.
//
// A free-running timer issues a trigger every PERIOD clocks while enable is
// high. Each accepted trigger runs one frame: CS setup, 16 SCLK cycles
// (falling edge first, the receiver samples SDATA on SCLK falling edges),
// CS hold, then a quiet gap with CS high. A trigger that arrives while a
// frame is in progress does not start a frame; it sets the sticky overrun
// flag instead.
//
// Parameters:
//   DIV_HALF  system clocks per SCLK half-period (1..255)
//   PERIOD    system clocks between triggers (2..65535)
//   QUIET     clocks CS stays high after a frame (1..255)
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   enable     in   continuous sampling enable (level)
//   clear_ovr  in   one-clock pulse clearing overrun
//   CS         out  ADC chip select, active-low, registered
//   SCLK       out  ADC serial clock, idle high, registered
//   busy       out  high whenever the sequencer is not idle
//   frame_done out  one-clock pulse on the first clock after CS returns high
//   overrun    out  sticky: trigger seen while busy
//   sample_cnt out  completed-frame count, wraps at 65535
module adc_spi_ctrl #(
    parameter int DIV_HALF = 2,
    parameter int PERIOD   = 2000,
    parameter int QUIET    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_ovr,
    output logic        CS,
    output logic        SCLK,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic [15:0] sample_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [7:0]  DIV_LAST    = 8'(DIV_HALF - 1);
    localparam logic [7:0]  QUIET_LAST  = 8'(QUIET - 1);
    localparam logic [15:0] PERIOD_LAST = 16'(PERIOD - 1);

    state_t      state;
    logic [15:0] timer;
    logic [7:0]  div_cnt;   // clocks spent in the current phase / half-period
    logic [4:0]  half_cnt;  // SCLK half-period index within SHIFT, 0..31
    logic        trigger;

    assign trigger = enable && (timer == 16'd0);
    assign busy    = (state != IDLE);

    // Trigger timer: counts 0..PERIOD-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= 16'd0;
        end else if (!enable) begin
            timer <= 16'd0;
        end else if (timer == PERIOD_LAST) begin
            timer <= 16'd0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

    // Sticky overrun; a new event in the same clock wins over clear_ovr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (trigger && busy) begin
            overrun <= 1'b1;
        end else if (clear_ovr) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun;
        end
    end

    // Frame sequencer with registered CS/SCLK/frame_done/sample_cnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            CS         <= 1'b1;
            SCLK       <= 1'b1;
            div_cnt    <= 8'd0;
            half_cnt   <= 5'd0;
            frame_done <= 1'b0;
            sample_cnt <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    CS       <= 1'b1;
                    SCLK     <= 1'b1;
                    div_cnt  <= 8'd0;
                    half_cnt <= 5'd0;
                    if (trigger) begin
                        state <= SETUP;
                        CS    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        // First falling edge marks entry into SHIFT.
                        state    <= SHIFT;
                        SCLK     <= 1'b0;
                        div_cnt  <= 8'd0;
                        half_cnt <= 5'd0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= 8'd0;
                        if (half_cnt == 5'd31) begin
                            // Last half-period (high after 16th rise) done.
                            state <= HOLD;
                            SCLK  <= 1'b1;
                        end else begin
                            SCLK     <= ~SCLK;
                            half_cnt <= half_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    SCLK <= 1'b1;
                    if (div_cnt == DIV_LAST) begin
                        state      <= GAP;
                        CS         <= 1'b1;
                        div_cnt    <= 8'd0;
                        frame_done <= 1'b1;
                        sample_cnt <= sample_cnt + 16'd1;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    CS   <= 1'b1;
                    SCLK <= 1'b1;
                    if (div_cnt == QUIET_LAST) begin
                        state   <= IDLE;
                        div_cnt <= 8'd0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    CS       <= 1'b1;
                    SCLK     <= 1'b1;
                    div_cnt  <= 8'd0;
                    half_cnt <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// tb_adc_spi_ctrl: directed self-checking bench for adc_spi_ctrl.
// Instance a uses default parameters; instance b uses PERIOD=50 (shorter
// than a frame); instance c uses PERIOD=72 so a trigger lands on the clock
// the sequencer returns to IDLE. An SDATA source model and a falling-edge
// receiver are attached to instance a.
module tb_adc_spi_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, enable_a, clear_a;
    logic cs_a, sclk_a, busy_a, done_a, ovr_a;
    logic [15:0] cnt_a;

    logic reset_bc, enable_bc, clear_bc;
    logic cs_b, sclk_b, busy_b, done_b, ovr_b;
    logic [15:0] cnt_b;
    logic cs_c, sclk_c, busy_c, done_c, ovr_c;
    logic [15:0] cnt_c;

    adc_spi_ctrl dut_a (
        .clk(clk), .reset(reset_a), .enable(enable_a), .clear_ovr(clear_a),
        .CS(cs_a), .SCLK(sclk_a), .busy(busy_a), .frame_done(done_a),
        .overrun(ovr_a), .sample_cnt(cnt_a)
    );

    adc_spi_ctrl #(.PERIOD(50)) dut_b (
        .clk(clk), .reset(reset_bc), .enable(enable_bc), .clear_ovr(clear_bc),
        .CS(cs_b), .SCLK(sclk_b), .busy(busy_b), .frame_done(done_b),
        .overrun(ovr_b), .sample_cnt(cnt_b)
    );

    adc_spi_ctrl #(.PERIOD(72)) dut_c (
        .clk(clk), .reset(reset_bc), .enable(enable_bc), .clear_ovr(clear_bc),
        .CS(cs_c), .SCLK(sclk_c), .busy(busy_c), .frame_done(done_c),
        .overrun(ovr_c), .sample_cnt(cnt_c)
    );

    // Posedge count: cyc == k right after the k-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor of instance a sampled on the falling clock edge.
    int falls_a = 0, csfalls_a = 0, dones_a = 0, viol_a = 0;
    int low_run_a = 0, low_len_a = 0, last_fall_a = 0, prev_fall_a = 0;
    logic prev_cs_a = 1'b1, prev_sclk_a = 1'b1;
    always @(negedge clk) begin
        if (prev_sclk_a && !sclk_a) falls_a <= falls_a + 1;
        if ((sclk_a !== prev_sclk_a) && cs_a && prev_cs_a) viol_a <= viol_a + 1;
        if (prev_cs_a && !cs_a) begin
            csfalls_a   <= csfalls_a + 1;
            last_fall_a <= cyc;
            prev_fall_a <= last_fall_a;
            low_run_a   <= 1;
        end else if (!cs_a) begin
            low_run_a <= low_run_a + 1;
        end
        if (!prev_cs_a && cs_a) low_len_a <= low_run_a;
        if (done_a) dones_a <= dones_a + 1;
        prev_cs_a   <= cs_a;
        prev_sclk_a <= sclk_a;
    end

    // ADC model: MSB first, next bit presented after each SCLK rise.
    logic [15:0] tx_word = 16'h0000;
    logic [15:0] rx_word = 16'h0000;
    logic [4:0]  bit_idx = 5'd0;
    logic        sdata;
    always @(posedge cs_a or posedge sclk_a) begin
        if (cs_a) bit_idx <= 5'd0;
        else      bit_idx <= bit_idx + 5'd1;
    end
    assign sdata = (bit_idx < 5'd16) ? tx_word[4'd15 - bit_idx[3:0]] : 1'b0;
    // Receiver: shifts SDATA in on each SCLK falling edge.
    always @(negedge sclk_a) rx_word <= {rx_word[14:0], sdata};

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_done_a(input string tag, input int limit);
        int k;
        k = 0;
        while (!done_a && k < limit) begin
            tick();
            k++;
        end
        check(tag, 32'(k < limit), 32'd1);
    endtask

    int n0, m0, k, base_falls, base_cs, base_done;

    initial begin
        reset_a = 1'b1; enable_a = 1'b0; clear_a = 1'b0;
        reset_bc = 1'b1; enable_bc = 1'b0; clear_bc = 1'b0;
        tick(); tick();

        // Reset state.
        check("rst_cs", 32'(cs_a), 32'd1);
        check("rst_sclk", 32'(sclk_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_ovr", 32'(ovr_a), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);

        reset_a = 1'b0;
        repeat (5) tick();
        check("idle_no_enable_cs", 32'(cs_a), 32'd1);
        check("idle_no_enable_busy", 32'(busy_a), 32'd0);

        // First frame with enable from idle, word 0xA5C3.
        tx_word    = 16'hA5C3;
        base_falls = falls_a;
        base_cs    = csfalls_a;
        base_done  = dones_a;
        n0         = cyc;
        enable_a   = 1'b1;
        tick();
        check("cs_fall_latency", 32'(cs_a), 32'd0);
        check("cs_fall_cycle", 32'(last_fall_a), 32'(n0 + 1));
        check("busy_in_frame", 32'(busy_a), 32'd1);
        wait_done_a("frame1_timeout", 200);
        tick();
        check("frame1_falls", 32'(falls_a - base_falls), 32'd16);
        check("frame1_cs_low", 32'(low_len_a), 32'd68);
        check("frame1_done_pulses", 32'(dones_a - base_done), 32'd1);
        check("frame1_cnt", 32'(cnt_a), 32'd1);
        check("frame1_rx", 32'(rx_word), 32'h0000A5C3);

        // Second frame carries 0x0FFF.
        tx_word = 16'h0FFF;
        k = 0;
        while (cnt_a != 16'd2 && k < 2100) begin
            tick();
            k++;
        end
        check("frame2_timeout", 32'(k < 2100), 32'd1);
        check("frame2_rx", 32'(rx_word), 32'h00000FFF);

        // Enable held 10000 clocks in total.
        wait_until(n0 + 10000);
        enable_a = 1'b0;
        tick();
        check("run_cs_falls", 32'(csfalls_a - base_cs), 32'd5);
        check("run_done_pulses", 32'(dones_a - base_done), 32'd5);
        check("run_cnt", 32'(cnt_a), 32'd5);
        check("run_falls", 32'(falls_a - base_falls), 32'd80);
        check("run_spacing", 32'(last_fall_a - prev_fall_a), 32'd2000);
        check("run_ovr", 32'(ovr_a), 32'd0);
        check("run_sclk_while_cs_high", 32'(viol_a), 32'd0);

        // Enable dropped after the 3rd falling edge.
        base_falls = falls_a;
        base_cs    = csfalls_a;
        enable_a   = 1'b1;
        k = 0;
        while (falls_a < base_falls + 3 && k < 100) begin
            tick();
            k++;
        end
        check("drop_edge3_timeout", 32'(k < 100), 32'd1);
        enable_a = 1'b0;
        wait_done_a("drop_timeout", 200);
        tick();
        check("drop_falls", 32'(falls_a - base_falls), 32'd16);
        check("drop_cnt", 32'(cnt_a), 32'd6);
        repeat (3000) tick();
        check("drop_cs_falls", 32'(csfalls_a - base_cs), 32'd1);
        check("drop_idle_busy", 32'(busy_a), 32'd0);
        check("drop_idle_cs", 32'(cs_a), 32'd1);

        // Asynchronous reset after the 7th falling edge.
        tx_word    = 16'h3C5A;
        base_falls = falls_a;
        enable_a   = 1'b1;
        k = 0;
        while (falls_a < base_falls + 7 && k < 100) begin
            tick();
            k++;
        end
        check("abort_edge7_timeout", 32'(k < 100), 32'd1);
        #2;
        reset_a = 1'b1;
        #1;
        check("abort_cs", 32'(cs_a), 32'd1);
        check("abort_sclk", 32'(sclk_a), 32'd1);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_cnt", 32'(cnt_a), 32'd0);
        check("abort_ovr", 32'(ovr_a), 32'd0);
        tick();
        base_falls = falls_a;
        reset_a    = 1'b0;
        wait_done_a("after_abort_timeout", 200);
        tick();
        check("after_abort_falls", 32'(falls_a - base_falls), 32'd16);
        check("after_abort_cs_low", 32'(low_len_a), 32'd68);
        check("after_abort_rx", 32'(rx_word), 32'h00003C5A);
        check("after_abort_cnt", 32'(cnt_a), 32'd1);
        enable_a = 1'b0;

        // Overrun instances: PERIOD 50 (b) and 72 (c).
        tick();
        check("bc_rst_ovr", 32'(ovr_b), 32'd0);
        reset_bc = 1'b0;
        tick();
        m0        = cyc;
        enable_bc = 1'b1;
        wait_until(m0 + 50);
        check("b_ovr_before_trig", 32'(ovr_b), 32'd0);
        wait_until(m0 + 51);
        check("b_ovr_set", 32'(ovr_b), 32'd1);
        wait_until(m0 + 69);
        check("b_cnt_frame1", 32'(cnt_b), 32'd1);
        check("b_done_pulse", 32'(done_b), 32'd1);
        check("c_ovr_before", 32'(ovr_c), 32'd0);
        wait_until(m0 + 72);
        check("c_busy_in_gap", 32'(busy_c), 32'd1);
        check("c_ovr_in_gap", 32'(ovr_c), 32'd0);
        wait_until(m0 + 73);
        check("c_idle_entry_busy", 32'(busy_c), 32'd0);
        check("c_idle_entry_ovr", 32'(ovr_c), 32'd1);
        check("c_idle_entry_cs", 32'(cs_c), 32'd1);
        check("c_cnt", 32'(cnt_c), 32'd1);
        wait_until(m0 + 74);
        check("c_no_start_busy", 32'(busy_c), 32'd0);
        check("c_no_start_cs", 32'(cs_c), 32'd1);
        wait_until(m0 + 79);
        clear_bc = 1'b1;
        tick();
        clear_bc = 1'b0;
        check("b_clear", 32'(ovr_b), 32'd0);
        wait_until(m0 + 101);
        check("b_frame2_cs", 32'(cs_b), 32'd0);
        check("b_frame2_ovr", 32'(ovr_b), 32'd0);
        wait_until(m0 + 150);
        clear_bc = 1'b1;
        tick();
        clear_bc = 1'b0;
        check("b_clear_vs_event", 32'(ovr_b), 32'd1);
        enable_bc = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
